// File: rtl/led_pkg.sv
// Shared defaults and types for the LED fade output stage.
package led_pkg;
    localparam int N_LED    = 6;
    localparam int PWM_BITS = 8;

    typedef logic [PWM_BITS-1:0] level_t;

    localparam level_t LEVEL_MAX = '1;
endpackage

// File: rtl/led_fade_chan.sv
// One LED channel: saturating level ramp toward a target, PWM compare, registered active-low pin.
module led_fade_chan #(
    parameter int PWM_BITS = led_pkg::PWM_BITS,
    parameter int STEP     = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                fade_tick,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    input  logic [PWM_BITS-1:0] target,
    output logic                led
);
    localparam logic [PWM_BITS:0]   STEP_W  = (PWM_BITS + 1)'(STEP);
    localparam logic [PWM_BITS-1:0] LVL_MAX = '1;

    logic [PWM_BITS-1:0] level_q, level_d;
    logic                led_q, led_d;
    logic [PWM_BITS:0]   wide, tgt_w, up, dn;
    logic                lit;

    // One extra bit: a set MSB on dn means the step went below zero.
    always_comb begin
        wide    = {1'b0, level_q};
        tgt_w   = {1'b0, target};
        up      = wide + STEP_W;
        dn      = wide - STEP_W;
        level_d = level_q;
        if (fade_tick) begin
            if (wide < tgt_w) begin
                level_d = (up > tgt_w) ? target : up[PWM_BITS-1:0];
            end else if (wide > tgt_w) begin
                level_d = (dn[PWM_BITS] || (dn < tgt_w)) ? target : dn[PWM_BITS-1:0];
            end
        end
    end

    always_comb begin
        lit   = (level_q == LVL_MAX) || (pwm_cnt < level_q);
        led_d = ~lit;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level_q <= '0;
            led_q   <= 1'b1;
        end else begin
            level_q <= level_d;
            led_q   <= led_d;
        end
    end

    assign led = led_q;
endmodule

// File: rtl/led_fade_driver.sv
// Per-LED PWM fade driver: input register, fade-tick divider, shared PWM counter, N_LED channels.
module led_fade_driver #(
    parameter int N_LED    = led_pkg::N_LED,
    parameter int PWM_BITS = led_pkg::PWM_BITS,
    parameter int FADE_DIV = 26000,
    parameter int STEP     = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_LED-1:0]    led_in,
    input  logic [PWM_BITS-1:0] bright,
    output logic [N_LED-1:0]    led
);
    localparam int DIV_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;

    logic [N_LED-1:0]    req_q, req_d;
    logic [PWM_BITS-1:0] bright_q, bright_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic                fade_tick;
    logic [PWM_BITS-1:0] target [N_LED];

    always_comb begin
        req_d     = led_in;
        bright_d  = bright;
        pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
        fade_tick = (div_q == DIV_W'(FADE_DIV - 1));
        div_d     = fade_tick ? '0 : div_q + DIV_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_q     <= '1;
            bright_q  <= '0;
            pwm_cnt_q <= '0;
            div_q     <= '0;
        end else begin
            req_q     <= req_d;
            bright_q  <= bright_d;
            pwm_cnt_q <= pwm_cnt_d;
            div_q     <= div_d;
        end
    end

    // Active-low request: a 0 bit asks for the global brightness.
    generate
        for (genvar gi = 0; gi < N_LED; gi++) begin : g_chan
            assign target[gi] = req_q[gi] ? '0 : bright_q;

            led_fade_chan #(
                .PWM_BITS (PWM_BITS),
                .STEP     (STEP)
            ) u_chan (
                .clk       (clk),
                .rst       (rst),
                .fade_tick (fade_tick),
                .pwm_cnt   (pwm_cnt_q),
                .target    (target[gi]),
                .led       (led[gi])
            );
        end
    endgenerate
endmodule

// File: tb/tb_led_fade_driver.sv
// Directed bench for led_fade_driver with FADE_DIV=4, STEP=16, PWM_BITS=8.
module tb_led_fade_driver;
    import led_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] led_in = 6'h3F;
    logic [7:0] bright = 8'd255;
    logic [5:0] led_o;

    int n_cmp = 0;
    int n_bad = 0;

    led_fade_driver #(
        .N_LED    (6),
        .PWM_BITS (8),
        .FADE_DIV (4),
        .STEP     (16)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .led_in (led_in),
        .bright (bright),
        .led    (led_o)
    );

    always #5 clk = ~clk;

    level_t level0;
    assign level0 = dut.g_chan[0].u_chan.level_q;

    task automatic step_cycle();
        @(posedge clk);
        #1;
    endtask

    // Advance until level0 changes (bounded); returns cycles taken, or 99 on timeout.
    task automatic wait_level_change(output int cycles);
        level_t prev;
        prev   = level0;
        cycles = 99;
        for (int i = 1; i <= 40; i++) begin
            step_cycle();
            if (level0 !== prev) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int bad;
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if (led_o !== 6'h3F) begin
            n_bad++;
            $display("FAIL reset_async_led got=%h want=3f", led_o);
        end
        repeat (3) step_cycle();
        #2 rst = 1'b1;
        bad = 0;
        for (int i = 0; i < 2000; i++) begin
            step_cycle();
            if (led_o !== 6'h3F || level0 !== 8'd0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL reset_idle_2000 bad_cycles=%0d want=0 led=%h level0=%0d", bad, led_o, level0);
        end
        $display("test_reset: led=%h level0=%0d", led_o, level0);
    endtask

    task automatic test_ramp_up();
        int     cyc;
        int     bad;
        level_t exp;
        led_in = 6'h3E;
        for (int k = 1; k <= 16; k++) begin
            exp = (k == 16) ? LEVEL_MAX : level_t'(16 * k);
            wait_level_change(cyc);
            n_cmp++;
            if (level0 !== exp) begin
                n_bad++;
                $display("FAIL ramp_up_step%0d level0=%0d want=%0d", k, level0, exp);
            end
            if (k > 1) begin
                n_cmp++;
                if (cyc != 4) begin
                    n_bad++;
                    $display("FAIL ramp_up_gap%0d cycles=%0d want=4", k, cyc);
                end
            end
        end
        repeat (2) step_cycle();
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            step_cycle();
            if (led_o !== 6'h3E) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL ramp_up_full_on bad_cycles=%0d want=0 led=%h", bad, led_o);
        end
        $display("test_ramp_up: level0=%0d led=%h", level0, led_o);
    endtask

    task automatic test_duty();
        int lows;
        int others_bad;
        bright = 8'd64;
        for (int i = 0; i < 300 && level0 !== 8'd64; i++) step_cycle();
        n_cmp++;
        if (level0 !== 8'd64) begin
            n_bad++;
            $display("FAIL duty_settle level0=%0d want=64", level0);
        end
        repeat (4) step_cycle();
        for (int w = 0; w < 2; w++) begin
            lows       = 0;
            others_bad = 0;
            for (int i = 0; i < 256; i++) begin
                step_cycle();
                if (led_o[0] === 1'b0) lows++;
                if (led_o[5:1] !== 5'h1F) others_bad++;
            end
            n_cmp++;
            if (lows != 64 || others_bad != 0) begin
                n_bad++;
                $display("FAIL duty_window%0d low_cycles=%0d want=64 other_bad=%0d want=0", w, lows, others_bad);
            end
            $display("test_duty: window=%0d low_cycles=%0d", w, lows);
        end
    endtask

    task automatic test_reverse();
        int cyc;
        int bad;
        bright = 8'd255;
        for (int i = 0; i < 8 && level0 !== 8'd128; i++) wait_level_change(cyc);
        n_cmp++;
        if (level0 !== 8'd128) begin
            n_bad++;
            $display("FAIL reverse_reach128 level0=%0d want=128", level0);
        end
        led_in = 6'h3F;
        for (int k = 1; k <= 8; k++) begin
            wait_level_change(cyc);
            n_cmp++;
            if (level0 !== level_t'(128 - 16 * k)) begin
                n_bad++;
                $display("FAIL reverse_step%0d level0=%0d want=%0d", k, level0, 128 - 16 * k);
            end
        end
        repeat (2) step_cycle();
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            step_cycle();
            if (led_o !== 6'h3F || level0 !== 8'd0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL reverse_dark bad_cycles=%0d want=0 led=%h", bad, led_o);
        end
        $display("test_reverse: level0=%0d led=%h", level0, led_o);
    endtask

    task automatic test_bright_change();
        int cyc;
        int bad;
        led_in = 6'h3E;
        bright = 8'd255;
        for (int i = 0; i < 200 && level0 !== 8'd255; i++) step_cycle();
        n_cmp++;
        if (level0 !== 8'd255) begin
            n_bad++;
            $display("FAIL bright_settle255 level0=%0d want=255", level0);
        end
        bright = 8'd40;
        for (int k = 1; k <= 14; k++) begin
            wait_level_change(cyc);
            n_cmp++;
            if (level0 !== ((k == 14) ? 8'd40 : level_t'(255 - 16 * k))) begin
                n_bad++;
                $display("FAIL bright_step%0d level0=%0d want=%0d", k, level0, (k == 14) ? 40 : 255 - 16 * k);
            end
        end
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            step_cycle();
            if (level0 !== 8'd40) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL bright_hold40 bad_cycles=%0d want=0 level0=%0d", bad, level0);
        end
        $display("test_bright_change: level0=%0d", level0);
    endtask

    task automatic test_async_reset();
        int cyc;
        led_in = 6'h3F;
        for (int i = 0; i < 100 && level0 !== 8'd0; i++) step_cycle();
        led_in = 6'h3E;
        bright = 8'd255;
        for (int i = 0; i < 8 && level0 !== 8'd80; i++) wait_level_change(cyc);
        n_cmp++;
        if (level0 !== 8'd80) begin
            n_bad++;
            $display("FAIL areset_reach80 level0=%0d want=80", level0);
        end
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if (led_o !== 6'h3F || level0 !== 8'd0) begin
            n_bad++;
            $display("FAIL areset_immediate led=%h want=3f level0=%0d want=0", led_o, level0);
        end
        repeat (3) step_cycle();
        #2 rst = 1'b1;
        repeat (3) step_cycle();
        n_cmp++;
        if (level0 !== 8'd0) begin
            n_bad++;
            $display("FAIL areset_edge3 level0=%0d want=0", level0);
        end
        step_cycle();
        n_cmp++;
        if (level0 !== 8'd16) begin
            n_bad++;
            $display("FAIL areset_first_tick level0=%0d want=16", level0);
        end
        $display("test_async_reset: level0=%0d led=%h", level0, led_o);
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_duty();
        test_reverse();
        test_bright_change();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/led_fade_driver.md
# led_fade_driver

Output stage between the seconds-counter LED stage and the board LED pins. Takes the 6-bit active-low LED pattern produced by the counter stage and drives the pins with per-LED PWM. Each LED ramps its brightness smoothly toward on or off instead of switching hard. A global brightness input caps the on-level of every LED.

## Interface
- `N_LED`, 6: number of LED channels.
- `PWM_BITS`, 8: width of the PWM counter and of the per-LED level.
- `FADE_DIV`, 26000: clock cycles per fade tick; legal range ≥ 1.
- `STEP`, 1: level change per fade tick; legal range 1 .. 2^PWM_BITS−1.

- `clk`, in, 1: single clock; every register is on the rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `led_in`, in, N_LED: pattern from the counter stage; active-low, so 0 means LED requested on. Same clock domain as `clk`.
- `bright`, in, PWM_BITS: global on-level; 0 means fully dark.
- `led`, out, N_LED: pin drive; active-low, so 0 means LED lit.

## Operation
**Input register**
- `led_in` and `bright` are registered once, giving `req_q` and `bright_q`.
- Per-LED target: `bright_q` if `req_q[i]==0`, else 0.

**Fade divider**
- Counter `div` runs 0..FADE_DIV−1.
- `fade_tick` is high for one cycle when `div==FADE_DIV−1`; `div` then wraps to 0.
- With FADE_DIV=1, `fade_tick` is high every cycle.

**Level update** (per LED, only on `fade_tick`)
- If level < target: level ← min(level+STEP, target).
- If level > target: level ← max(level−STEP, target).
- If equal: hold.
- Arithmetic is done one bit wider than PWM_BITS, so no wrap-around is possible.
- A target change mid-ramp reverses direction from the current level; there is no restart from 0.
- A change of `bright` while the LED is requested on ramps the level to the new `bright` in either direction.

**PWM**
- `pwm_cnt` is a free-running PWM_BITS counter that wraps 2^PWM_BITS−1 → 0.
- `lit[i]` = (level == 2^PWM_BITS−1) OR (pwm_cnt < level).
- Level 0 is never lit. Level max is always lit.
- `led[i]` is the registered value of `~lit[i]`.

## Timing
**Reset values (rst low)**
- `led` = all ones (all LEDs dark).
- Levels 0, `pwm_cnt` 0, `div` 0, `req_q` all ones, `bright_q` 0.
- Assertion takes effect asynchronously, so `led` goes high without waiting for a clock edge.
- Release is synchronous to the next `clk` edge. The first `fade_tick` occurs FADE_DIV cycles after release.

**Latencies**
- `led_in` or `bright` change → new target: 1 cycle (the input register).
- Target → level starts moving: at the next `fade_tick` after the target updates.
- Level → pin: 1 cycle (the output register).

**Other timing rules**
- A full ramp 0 → B takes ceil(B/STEP) fade ticks.
- The PWM period is 2^PWM_BITS cycles. Duty at level L (L < max) is exactly L/2^PWM_BITS, measured over any aligned period.
- If `fade_tick` and a target change land in the same cycle, the tick uses the previous target. The new target applies from the next tick onward.
- Reset asserted mid-ramp aborts the ramp. No fading resumes after release; each level starts from 0.

## Structure
- Shared package `led_pkg` holds:
  - `N_LED` and `PWM_BITS` defaults;
  - `level_t`, a logic vector of width PWM_BITS;
  - the `LEVEL_MAX` constant.
- Sub-module `led_fade_chan`, instantiated N_LED times. Each instance holds one level register, the saturating step logic, the PWM comparator and the output flop.
  - Inputs: `clk`, `rst`, `fade_tick`, `pwm_cnt`, `target`.
  - Output: one active-low pin.
- The top level holds the input register, the fade divider and `pwm_cnt`.

## Test plan
All scenarios use PWM_BITS=8, FADE_DIV=4, STEP=16 unless stated otherwise.

1. Reset with `led_in`=6'h3F and `bright`=255, run 2000 cycles → `led` stays 6'h3F and all levels stay 0.
2. With `bright`=255, set `led_in`=6'h3E → level0 steps 16, 32, … on each `fade_tick` and reaches 255 after 16 ticks (64 cycles, final step clamped). After that `led[0]` is constantly 0 and `led[5:1]` are constantly 1.
3. With `bright`=64 and `led_in[0]`=0, let level0 settle at 64 → over every 256-cycle aligned window, `led[0]` is low for exactly 64 cycles.
4. At level0=128 during a rise, set `led_in`=6'h3F → level0 goes 112, 96, …, 0 (8 ticks) with no overshoot. Duty falls to 0 and `led[0]` stays 1.
5. With LED0 settled at `bright`=255, change `bright` to 40 → level0 goes 239, 223, …, 47, then 40 (clamped on the 14th tick) and holds at 40.
6. Pull `rst` low mid-ramp (level0=80) between clock edges → `led` = 6'h3F immediately, before the next edge. After release with `led_in[0]` still 0, level0 restarts at 0 and reaches 16 on the first `fade_tick`, 4 cycles later.
